i2c_master_8_io_writer: RTL and testbench

Single-byte I2C write master, the initiator counterpart of our 8-bit I/O expander slave. On request it generates START, sends the 7-bit address with R/W=0, sends one data byte, checks both ACKs, and generates STOP. Only the write direction is supported; no read, no repeated START. It sits on the board-controller side and drives expander ports across the bus with open-drain SDA/SCL.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_quarter_gen.sv | 45 ++++
 rtl/i2c_master_8_io_writer.sv | 155 +++++++++++++++
 tb/tb_i2c_master_8_io_writer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C write master.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_STOP,
    ST_DONE
  } i2c_state_t;

  localparam logic RW_WRITE         = 1'b0;
  localparam int   QUARTERS_PER_BIT = 4;
  localparam int   START_QUARTERS   = 2;
  localparam int   STOP_QUARTERS    = 4;

  // START occupies the last quarters of a notional slot, so the first
  // address bit naturally begins at quarter index 0.
  localparam logic [1:0] START_QIDX = 2'(QUARTERS_PER_BIT - START_QUARTERS);
  localparam logic [1:0] LAST_QIDX  = 2'(QUARTERS_PER_BIT - 1);
  localparam logic [1:0] STOP_LAST  = 2'(STOP_QUARTERS - 1);

endpackage

// File: rtl/i2c_quarter_gen.sv
// SCL quarter-period generator: divider counter plus 2-bit quarter index.
// hold freezes the counter at 0 (clock stretching); restart re-aligns it.
module i2c_quarter_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       start_and_reset_delayed,
  input  logic       run,
  input  logic       restart,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] qidx
);

  localparam int             CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          stalled;

  // Stretch only freezes the counter at the very start of a quarter.
  assign stalled = hold && (cnt == '0);
  assign tick    = run && !stalled && (cnt == CNT_MAX);

  // Divider counter and quarter index, advancing on each wrap.
  always_ff @(posedge clk or negedge start_and_reset_delayed) begin
    if (!start_and_reset_delayed) begin
      cnt  <= '0;
      qidx <= 2'd0;
    end else if (restart) begin
      cnt  <= '0;
      qidx <= START_QIDX;
    end else if (run && !stalled) begin
      if (cnt == CNT_MAX) begin
        cnt  <= '0;
        qidx <= qidx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_8_io_writer.sv
// Single-byte I2C write master: START, address+W, one data byte, STOP.
// Optional build macro I2C_MASTER_CLK_STRETCH_EN honours slave clock
// stretching at the SCL rising edges; without it the scl input is ignored.
module i2c_master_8_io_writer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       start_and_reset_delayed,
  input  logic       req,
  input  logic [6:0] adr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        scl,
  inout  wire        sda
);

  i2c_state_t state;
  logic [7:0] shift;
  logic [7:0] data_r;
  logic [2:0] bit_cnt;
  logic       nack;
  logic       scl_oe;
  logic       sda_oe;
  logic       tick;
  logic [1:0] qidx;
  logic       hold;
  logic       restart;

  // Open-drain pads: pull low or release, never drive high.
  assign scl = scl_oe ? 1'b0 : 1'bz;
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign restart = (state == ST_IDLE) && req;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // Wait for scl to actually rise wherever the master has just released it.
  assign hold = !scl &&
                (((state inside {ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK}) && qidx == 2'd2) ||
                 (state == ST_STOP && qidx == 2'd1));
`else
  assign hold = 1'b0;
`endif

  i2c_quarter_gen #(.CLK_DIV(CLK_DIV)) u_qgen (
    .clk                     (clk),
    .start_and_reset_delayed (start_and_reset_delayed),
    .run                     (busy),
    .restart                 (restart),
    .hold                    (hold),
    .tick                    (tick),
    .qidx                    (qidx)
  );

  // Transfer sequencer; pad enables are set for the quarter being entered.
  always_ff @(posedge clk or negedge start_and_reset_delayed) begin
    if (!start_and_reset_delayed) begin
      state   <= ST_IDLE;
      shift   <= '0;
      data_r  <= '0;
      bit_cnt <= '0;
      nack    <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            shift   <= {adr, RW_WRITE};
            data_r  <= data;
            bit_cnt <= '0;
            nack    <= 1'b0;
            ack_err <= 1'b0;
            busy    <= 1'b1;
            sda_oe  <= 1'b1;
            scl_oe  <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (tick && qidx == LAST_QIDX) begin
            scl_oe <= 1'b1;
            sda_oe <= ~shift[7];
            state  <= ST_ADDR;
          end
        end
        ST_ADDR, ST_DATA: begin
          if (tick) begin
            case (qidx)
              2'd1: scl_oe <= 1'b0;
              2'd3: begin
                scl_oe <= 1'b1;
                if (bit_cnt == 3'd7) begin
                  sda_oe <= 1'b0;
                  state  <= (state == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  shift   <= {shift[6:0], 1'b0};
                  sda_oe  <= ~shift[6];
                end
              end
              default: ;
            endcase
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (tick) begin
            case (qidx)
              2'd1: scl_oe <= 1'b0;
              2'd2: if (sda) nack <= 1'b1;
              2'd3: begin
                scl_oe <= 1'b1;
                if (state == ST_ADDR_ACK && !nack) begin
                  shift   <= data_r;
                  bit_cnt <= '0;
                  sda_oe  <= ~data_r[7];
                  state   <= ST_DATA;
                end else begin
                  sda_oe <= 1'b1;
                  state  <= ST_STOP;
                end
              end
              default: ;
            endcase
          end
        end
        ST_STOP: begin
          if (tick) begin
            case (qidx)
              2'd0:      scl_oe <= 1'b0;
              2'd1:      sda_oe <= 1'b0;
              STOP_LAST: state  <= ST_DONE;
              default: ;
            endcase
          end
        end
        ST_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          ack_err <= nack;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_8_io_writer.sv
// Scoreboard bench for the I2C write master, with an I/O-expander slave
// model at address 0x20 listening on the pulled-up bus.
module tb_i2c_master_8_io_writer;

  localparam int         CLK_DIV = 4;
  localparam logic [6:0] SLV_ADR = 7'h20;

  logic       clk = 1'b0;
  logic       rstb;
  logic       req;
  logic [6:0] adr;
  logic [7:0] data;
  logic       busy, done, ack_err;
  wire        scl_bus, sda_bus;
  logic       slv_scl_oe = 1'b0;
  logic       slv_sda_oe = 1'b0;
  logic       nack_data = 1'b0;

  pullup (scl_bus);
  pullup (sda_bus);
  assign scl_bus = slv_scl_oe ? 1'b0 : 1'bz;
  assign sda_bus = slv_sda_oe ? 1'b0 : 1'bz;

  i2c_master_8_io_writer #(.CLK_DIV(CLK_DIV)) dut (
    .clk                     (clk),
    .start_and_reset_delayed (rstb),
    .req                     (req),
    .adr                     (adr),
    .data                    (data),
    .busy                    (busy),
    .done                    (done),
    .ack_err                 (ack_err),
    .scl                     (scl_bus),
    .sda                     (sda_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] rx_adr;
    logic [7:0] rx_dat;
    logic       chk_dat;
    logic [7:0] io;
    logic       aerr;
    int         lat;
    int         rises;
    int         gap;
  } exp_t;

  exp_t sbq[$];

  // Slave model: START/STOP detect, sample on scl rise, ACK in the 9th slot.
  logic       sp = 1'b1, dp = 1'b1;
  logic       in_frame = 1'b0;
  int         bitn = 0, byte_idx = 0, rises = 0;
  logic [7:0] sh = '0, rx_adr = '0, rx_dat = '0, io = '0;
  logic       stop_seen = 1'b0, adr_ok = 1'b0;

  always @(negedge clk) begin
    logic s, d;
    s = (scl_bus !== 1'b0);
    d = (sda_bus !== 1'b0);
    if (sp && s && dp && !d) begin
      in_frame = 1'b1; bitn = 0; byte_idx = 0; rises = 0;
      stop_seen = 1'b0; slv_sda_oe = 1'b0;
    end else if (sp && s && !dp && d) begin
      in_frame = 1'b0; stop_seen = 1'b1; slv_sda_oe = 1'b0;
    end else if (in_frame) begin
      if (!sp && s) begin
        rises++;
        if (bitn < 8) sh = {sh[6:0], d};
        bitn++;
      end else if (sp && !s) begin
        if (bitn == 8) begin
          if (byte_idx == 0) begin
            rx_adr = sh;
            adr_ok = (sh[7:1] == SLV_ADR) && (sh[0] == 1'b0);
            slv_sda_oe = adr_ok;
          end else begin
            rx_dat = sh;
            if (adr_ok && !nack_data) begin
              io = sh;
              slv_sda_oe = 1'b1;
            end
          end
        end else if (bitn == 9) begin
          slv_sda_oe = 1'b0;
          bitn = 0;
          byte_idx++;
        end
      end
    end
    sp = s;
    dp = d;
  end

  // Monitor: pops the scoreboard on every done pulse.
  int   cyc = 0, rise_cyc = 0, last_done = -100, meas_gap = 0;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rstb) begin
      busy_q = 1'b0;
    end else begin
      if (busy && !busy_q) begin
        rise_cyc = cyc;
        meas_gap = cyc - last_done;
        chk("ack_err_cleared_on_accept", int'(ack_err), 0);
      end
      if (done) begin
        last_done = cyc;
        if (sbq.size() == 0) begin
          chk("unexpected_done_pending", 0, 1);
        end else begin
          e = sbq.pop_front();
          chk("done_latency", cyc - rise_cyc, e.lat);
          chk("ack_err", int'(ack_err), int'(e.aerr));
          chk("busy_at_done", int'(busy), 0);
          chk("rx_adr_byte", int'(rx_adr), int'(e.rx_adr));
          if (e.chk_dat) chk("rx_data_byte", int'(rx_dat), int'(e.rx_dat));
          chk("slave_io", int'(io), int'(e.io));
          chk("scl_rises", rises, e.rises);
          chk("stop_seen", int'(stop_seen), 1);
          if (e.gap >= 0) chk("busy_low_gap", meas_gap, e.gap);
        end
      end
      busy_q = busy;
    end
  end

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (sbq.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("transfer_timeout_pending", sbq.size(), 0);
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic xfer(input logic [6:0] a, input logic [7:0] d, input exp_t e);
    sbq.push_back(e);
    @(negedge clk);
    req = 1'b1; adr = a; data = d;
    @(negedge clk);
    req = 1'b0;
    wait_drain(1000);
  endtask

  function automatic exp_t mk(input logic [7:0] ra, input logic [7:0] rd, input logic cd,
                              input logic [7:0] i, input logic ae, input int lat,
                              input int r, input int g);
    exp_t e;
    e.rx_adr = ra; e.rx_dat = rd; e.chk_dat = cd; e.io = i;
    e.aerr = ae; e.lat = lat; e.rises = r; e.gap = g;
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog_expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    rstb = 1'b0; req = 1'b0; adr = '0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ack_err", int'(ack_err), 0);
    chk("rst_scl_released", int'(scl_bus), 1);
    chk("rst_sda_released", int'(sda_bus), 1);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Write ACKed: 78*4+1 cycles, 18 slots plus the STOP scl rise.
    xfer(7'h20, 8'hA5, mk(8'h40, 8'hA5, 1'b1, 8'hA5, 1'b0, 313, 19, -1));

    // Address NACK: 42*4+1 cycles, 9 slots plus STOP rise, io untouched.
    xfer(7'h21, 8'h3C, mk(8'h42, 8'h00, 1'b0, 8'hA5, 1'b1, 169, 10, -1));
    repeat (5) @(negedge clk);
    chk("ack_err_held", int'(ack_err), 1);

    // Data NACK: full frame, ack_err set, io untouched.
    nack_data = 1'b1;
    xfer(7'h20, 8'h5A, mk(8'h40, 8'h5A, 1'b1, 8'hA5, 1'b1, 313, 19, -1));
    nack_data = 1'b0;

    // Back-to-back with req held high across done.
    sbq.push_back(mk(8'h40, 8'h01, 1'b1, 8'h01, 1'b0, 313, 19, -1));
    sbq.push_back(mk(8'h40, 8'hFE, 1'b1, 8'hFE, 1'b0, 313, 19, 1));
    @(negedge clk);
    req = 1'b1; adr = 7'h20; data = 8'h01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 1000);
    data = 8'hFE;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 10);
    req = 1'b0;
    wait_drain(1000);

    // Reset during DATA bit 3 (quarter 51, q1 with scl low).
    @(negedge clk);
    req = 1'b1; adr = 7'h20; data = 8'h77;
    @(negedge clk);
    req = 1'b0;
    repeat (205) @(negedge clk);
    chk("scl_low_before_reset", int'(scl_bus), 0);
    rstb = 1'b0;
    #1;
    chk("mid_rst_scl_released", int'(scl_bus), 1);
    chk("mid_rst_sda_released", int'(sda_bus), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    xfer(7'h20, 8'hC3, mk(8'h40, 8'hC3, 1'b1, 8'hC3, 1'b0, 313, 19, -1));

`ifdef I2C_MASTER_CLK_STRETCH_EN
    // Slave holds scl low through ADDR bit 0 q2: counter frozen 10 cycles.
    sbq.push_back(mk(8'h40, 8'h96, 1'b1, 8'h96, 1'b0, 323, 19, -1));
    @(negedge clk);
    req = 1'b1; adr = 7'h20; data = 8'h96;
    @(negedge clk);
    req = 1'b0;
    repeat (15) @(negedge clk);
    slv_scl_oe = 1'b1;
    repeat (11) @(negedge clk);
    slv_scl_oe = 1'b0;
    wait_drain(1000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
